// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default data width and the bus word type.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/reg_ab_top_if.sv
// Control strobes and ALU operand path of a bus-attached register.
interface reg_ab_top_if #(
  parameter int unsigned WIDTH = cpu_pkg::DATA_W
) ();

  logic             ai_n;
  logic             ao_n;
  logic [WIDTH-1:0] A;

  modport slave  (input  ai_n, input  ao_n, output A);
  modport master (output ai_n, output ao_n, input  A);

endinterface

// File: rtl/reg_ab_top_bus_tristate.sv
// Active-low enabled tri-state driver onto the shared CPU bus.
module bus_tristate #(
  parameter int unsigned WIDTH = cpu_pkg::DATA_W
) (
  input  logic [WIDTH-1:0] data,
  input  logic             oe_n,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = oe_n ? 'z : data;

endmodule

// File: rtl/reg_ab_top.sv
// General-purpose A/B register: loads from the shared bus, drives it back on request,
// and always presents its value to the ALU.
module reg_ab_top
  import cpu_pkg::*;
#(
  parameter int unsigned     WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  inout  wire  [WIDTH-1:0] bus,
  reg_ab_top_if.slave      ctl
);

  logic [WIDTH-1:0] stored;
  logic             load;

  // A simultaneous load and output would capture our own drive, so output wins.
  assign load = !ctl.ai_n && ctl.ao_n;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stored <= RESET_VAL;
    end else if (load) begin
      stored <= bus;
    end
  end

  assign ctl.A = stored;

  bus_tristate #(.WIDTH(WIDTH)) u_bus_drv (
    .data (stored),
    .oe_n (ctl.ao_n),
    .bus  (bus)
  );

endmodule

// File: tb/tb_reg_ab_top.sv
// Directed and randomized checks of reg_ab_top against a simple stored-value model.
module tb_reg_ab_top;

  logic       clk;
  logic       clr_n;
  wire  [7:0] bus;
  logic [7:0] drv;
  logic       drv_en;
  int         total;
  int         bad;
  logic [7:0] model;

  reg_ab_top_if #(.WIDTH(8)) ctl ();

  assign bus = drv_en ? drv : 'z;

  reg_ab_top #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus),
    .ctl   (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [7:0] v);
    @(negedge clk);
    ctl.ai_n = 1'b0; ctl.ao_n = 1'b1; drv = v; drv_en = 1'b1;
    step();
    @(negedge clk);
    ctl.ai_n = 1'b1; drv_en = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    clr_n = 1'b0; ctl.ai_n = 1'b1; ctl.ao_n = 1'b1; drv = 8'h00; drv_en = 1'b0;
    #3;
    chk("reset_A", ctl.A, 8'h00);
    ctl.ao_n = 1'b0;
    #1;
    chk("reset_bus_drive", bus, 8'h00);
    ctl.ao_n = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;

    // Async clear between edges
    load_val(8'h55);
    chk("load_55", ctl.A, 8'h55);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_clear", ctl.A, 8'h00);
    clr_n = 1'b1;
    #1;
    chk("clear_after_release", ctl.A, 8'h00);
    step();
    chk("clear_held_edge", ctl.A, 8'h00);

    // Load and confirm the DUT leaves the bus alone
    @(negedge clk);
    ctl.ai_n = 1'b0; ctl.ao_n = 1'b1; drv = 8'hAA; drv_en = 1'b1;
    step();
    chk("load_AA", ctl.A, 8'hAA);
    @(negedge clk);
    ctl.ai_n = 1'b1; drv = 8'h0F;
    #1;
    chk("bus_not_driven_load", bus, 8'h0F);

    // Hold over three edges
    drv = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_AA", ctl.A, 8'hAA);
    end

    // Output enable drive and release
    @(negedge clk);
    drv_en = 1'b0; ctl.ao_n = 1'b0;
    #1;
    chk("oe_drive_AA", bus, 8'hAA);
    ctl.ao_n = 1'b1; drv = 8'h55; drv_en = 1'b1;
    #1;
    chk("oe_release", bus, 8'h55);
    drv_en = 1'b0;

    // Simultaneous ai_n/ao_n low
    load_val(8'h3C);
    ctl.ai_n = 1'b0; ctl.ao_n = 1'b0;
    #1;
    chk("both_low_bus", bus, 8'h3C);
    step();
    chk("both_low_A", ctl.A, 8'h3C);
    chk("both_low_bus_after", bus, 8'h3C);
    @(negedge clk);
    ctl.ai_n = 1'b1; ctl.ao_n = 1'b1;

    // Reset held across a load edge
    @(negedge clk);
    clr_n = 1'b0; ctl.ai_n = 1'b0; drv = 8'h81; drv_en = 1'b1;
    step();
    chk("reset_during_load", ctl.A, 8'h00);
    @(negedge clk);
    clr_n = 1'b1;
    step();
    chk("load_after_reset", ctl.A, 8'h81);
    @(negedge clk);
    ctl.ai_n = 1'b1; drv_en = 1'b0;

    // Randomized: stored value only changes on a clean load edge
    model = 8'h81;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      clr_n    = ($urandom_range(15) != 0);
      ctl.ai_n = $urandom_range(1);
      ctl.ao_n = $urandom_range(1);
      drv      = 8'($urandom);
      drv_en   = ctl.ao_n;
      if (!clr_n) model = 8'h00;
      #1;
      chk("rand_A_pre", ctl.A, model);
      chk("rand_bus", bus, ctl.ao_n ? drv : model);
      step();
      if (clr_n && !ctl.ai_n && ctl.ao_n) model = drv;
      chk("rand_A", ctl.A, model);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
